// File: rtl/sdiff_accum.sv
// Signed windowed accumulator: sums COUNT qualified difference samples with
// saturation and presents the window total with a one-cycle valid pulse.
module sdiff_accum #(
    parameter int unsigned DATAWIDTH = 2,
    parameter int unsigned ACCWIDTH  = 8,
    parameter int unsigned COUNT     = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] diff,
    input  logic                 diff_valid,
    output logic [ACCWIDTH-1:0]  sum,
    output logic                 sum_valid,
    output logic                 busy,
    output logic                 sat
);

    localparam int unsigned CntWidth = $clog2(COUNT + 1);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(COUNT - 1);
    localparam logic [ACCWIDTH-1:0] AccMax = {1'b0, {(ACCWIDTH-1){1'b1}}};
    localparam logic [ACCWIDTH-1:0] AccMin = {1'b1, {(ACCWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e                state_q, state_d;
    logic [ACCWIDTH-1:0]   acc_q, acc_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ACCWIDTH-1:0]   sum_q, sum_d;
    logic                  sat_q, sat_d;

    logic [ACCWIDTH:0]     diff_ext;
    logic [ACCWIDTH:0]     sum_wide;
    logic [ACCWIDTH-1:0]   acc_clamped;
    logic                  ovf_pos, ovf_neg;
    logic                  accept, clear, last;

    assign diff_ext = {{(ACCWIDTH + 1 - DATAWIDTH){diff[DATAWIDTH-1]}}, diff};
    assign sum_wide = {acc_q[ACCWIDTH-1], acc_q} + diff_ext;
    // Top two bits disagree only when the result left the ACCWIDTH signed range.
    assign ovf_pos  = ~sum_wide[ACCWIDTH] & sum_wide[ACCWIDTH-1];
    assign ovf_neg  = sum_wide[ACCWIDTH] & ~sum_wide[ACCWIDTH-1];

    always_comb begin
        acc_clamped = sum_wide[ACCWIDTH-1:0];
        if (ovf_pos) begin
            acc_clamped = AccMax;
        end else if (ovf_neg) begin
            acc_clamped = AccMin;
        end
    end

    assign accept = (state_q == StAccum) && diff_valid;
    assign clear  = start && ((state_q == StIdle) || (state_q == StDone));
    assign last   = (cnt_q == LastCnt);

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StAccum;
            StAccum: if (diff_valid && last) state_d = StDone;
            StDone:  state_d = start ? StAccum : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q == StAccum);
        sum_valid = (state_q == StDone);
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sum_d = sum_q;
        sat_d = sat_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (accept) begin
            acc_d = acc_clamped;
            cnt_d = cnt_q + 1'b1;
            sat_d = sat_q | ovf_pos | ovf_neg;
            if (last) begin
                sum_d = acc_clamped;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            sat_q <= sat_d;
        end
    end

    assign sum = sum_q;
    assign sat = sat_q;

endmodule

// File: tb/tb_sdiff_accum.sv
// Directed and randomized bench for sdiff_accum against a window-level
// reference model that folds the accepted samples with plain integer clamping.
module tb_sdiff_accum;

    localparam int DW  = 4;
    localparam int AW  = 5;
    localparam int CNT = 4;
    localparam int AccMax = (1 << (AW - 1)) - 1;
    localparam int AccMin = -(1 << (AW - 1));

    logic          Clk = 1'b0;
    logic          Rst;
    logic          start;
    logic [DW-1:0] diff;
    logic          diff_valid;
    logic [AW-1:0] sum;
    logic          sum_valid;
    logic          busy;
    logic          sat;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: samples of the open window, window phase and results
    int window[$];
    int m_mode;   // 0 idle, 1 collecting, 2 presenting total
    int m_sum;
    bit m_sat;

    sdiff_accum #(
        .DATAWIDTH(DW),
        .ACCWIDTH (AW),
        .COUNT    (CNT)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .diff      (diff),
        .diff_valid(diff_valid),
        .sum       (sum),
        .sum_valid (sum_valid),
        .busy      (busy),
        .sat       (sat)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_outputs();
        check("sum", sum, AW'(m_sum));
        check("sum_valid", AW'(sum_valid), AW'(m_mode == 2));
        check("busy", AW'(busy), AW'(m_mode == 1));
        check("sat", AW'(sat), AW'(m_sat));
    endtask

    task automatic model_reset();
        window.delete();
        m_mode = 0;
        m_sum  = 0;
        m_sat  = 1'b0;
    endtask

    task automatic model_edge(input bit st, input bit dv, input int d);
        int  acc;
        bit  clipped;
        case (m_mode)
            1: begin
                if (dv) begin
                    window.push_back(d);
                    acc     = 0;
                    clipped = 1'b0;
                    foreach (window[i]) begin
                        acc = acc + window[i];
                        if (acc > AccMax) begin
                            acc     = AccMax;
                            clipped = 1'b1;
                        end else if (acc < AccMin) begin
                            acc     = AccMin;
                            clipped = 1'b1;
                        end
                    end
                    m_sat = clipped;
                    if (window.size() == CNT) begin
                        m_sum  = acc;
                        m_mode = 2;
                    end
                end
            end
            default: begin
                if (st) begin
                    window.delete();
                    m_sat  = 1'b0;
                    m_mode = 1;
                end else begin
                    m_mode = 0;
                end
            end
        endcase
    endtask

    // Drive inputs away from the edge, clock once, then compare
    task automatic step(input bit st, input bit dv, input int d);
        logic [31:0] dv32;
        dv32       = d;
        start      = st;
        diff_valid = dv;
        diff       = dv32[DW-1:0];
        @(posedge Clk);
        model_edge(st, dv, d);
        #1;
        check_outputs();
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic async_reset();
        #2;
        Rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        int d0[4];
        Rst        = 1'b1;
        start      = 1'b0;
        diff_valid = 1'b0;
        diff       = '0;
        model_reset();
        #1;
        check_outputs();
        #2;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        check_outputs();

        // Back-to-back samples
        d0 = '{3, -2, 5, -1};
        step(1, 0, 0);
        foreach (d0[i]) step(0, 1, d0[i]);
        step(0, 0, 0);
        step(0, 0, 0);

        // Same samples with two-cycle gaps
        step(1, 0, 0);
        foreach (d0[i]) begin
            step(0, 1, d0[i]);
            step(0, 0, 0);
            step(0, 0, 0);
        end

        // Positive saturation then recovery
        step(1, 0, 0);
        repeat (4) step(0, 1, 7);
        step(1, 0, 0);
        repeat (4) step(0, 1, 1);
        step(0, 0, 0);

        // Negative saturation
        step(1, 0, 0);
        repeat (4) step(0, 1, -8);
        step(0, 0, 0);

        // diff_valid in idle and start mid-window are both ignored
        step(0, 1, 6);
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 2);
        step(1, 0, 0);
        step(1, 1, 3);
        step(0, 1, 4);
        step(0, 1, 5);

        // Async reset mid-window, then start held through DONE
        step(1, 0, 0);
        step(0, 1, 2);
        step(0, 1, 2);
        async_reset();
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (4) step(1, 1, 2);
        step(1, 0, 0);
        step(0, 1, -3);
        step(0, 1, 6);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 15)) - 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
